calyx_run_ctrl: RTL and testbench
=================================

Name: calyx_run_ctrl

Overview:
Synthesizable run controller for a Calyx `main` component. On a start request it holds the component in reset for a fixed number of cycles, then asserts `go` and counts cycles until `done` or a programmable cycle limit. It reports the cycle count and outcome as status. It sits between a host/CSR interface or on-chip harness and the compiled `main` go/done/reset pins.

Parameters:
RESET_CYCLES, 5, number of cycles main_reset is held after start before go (must be >=1)
CNT_W, 64, width of cycle counter and cycle_limit

Ports:
clk  input  1  clock
reset  input  1  reset; asynchronous, active-high
start  input  1  one-cycle run request
abort  input  1  cancel current run, return to IDLE
cycle_limit  input  CNT_W  max run cycles; 0 = unlimited; sampled on accepted start
main_done  input  1  done from Calyx main
main_go  output  1  go to Calyx main
main_reset  output  1  reset to Calyx main
busy  output  1  in RESET or RUN
finished  output  1  run ended by main_done
timed_out  output  1  run ended by cycle limit
cycles  output  CNT_W  run cycles elapsed (edges in RUN)

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous and active-high.
- All outputs are registered (Moore).
- Async reset values: state=IDLE, main_go=0, main_reset=1, busy=0, finished=0, timed_out=0, cycles=0, internal limit=0, reset-phase counter=0.
- IDLE:
  - main_reset=1, main_go=0.
  - On start=1: latch cycle_limit, clear cycles/finished/timed_out, go to RESET.
- RESET:
  - main_reset=1, busy=1.
  - Stays exactly RESET_CYCLES cycles (internal down-counter), then goes to RUN.
  - main_done is ignored here.
- RUN:
  - main_go=1, main_reset=0, busy=1.
  - Each edge in RUN increments cycles; saturates at all-ones, no wrap.
  - If main_done=1 at an edge: cycles increments for that edge, go to DONE, finished=1.
  - Else if limit!=0 and (cycles+1)==limit: go to DONE, timed_out=1.
  - main_done and limit reached on the same edge: done wins (finished=1, timed_out=0).
  - First RUN edge with main_done=1 gives cycles=1.
- DONE:
  - main_go=0, main_reset=0 (component state left observable), busy=0.
  - finished/timed_out/cycles hold.
  - start=1 restarts exactly as from IDLE (count and flags cleared).
- start while busy: ignored, no effect on count or limit.
- abort=1 in any state:
  - Go to IDLE next edge; main_go=0, main_reset=1, busy=0.
  - finished=0, timed_out=0; cycles retains its value.
  - abort has priority over start and main_done on the same edge.
- Async reset mid-run: immediate return to reset values regardless of clock; main_go drops asynchronously.
- Limit compare is full CNT_W unsigned; limit=1 ends RUN after one cycle if done is not seen.

Test Plan:
1. Reset, start pulse, limit=0, main_done raised on 10th RUN cycle -> main_reset high for 5 cycles after start, main_go high 10 cycles; then finished=1, cycles=10, busy=0.
2. limit=7, main_done never -> timed_out=1, finished=0, cycles=7, main_go low after 7 RUN cycles.
3. limit=4, main_done asserted on 4th RUN cycle -> finished=1, timed_out=0, cycles=4.
4. Start during RUN at cycle 3, then done at cycle 6 -> extra start ignored; cycles=6. A second start from DONE -> flags/count cleared, new 5-cycle reset phase.
5. abort at RUN cycle 5 with main_done=1 on same edge -> IDLE, main_reset=1, finished=0, cycles=5.
6. Async reset asserted mid-cycle during RUN -> main_go=0, main_reset=1, cycles=0 before the next clock edge.

Source files
------------

// File: rtl/calyx_run_ctrl.sv
// calyx_run_ctrl: run controller for a Calyx `main` component.
// A start request holds main in reset for RESET_CYCLES cycles, then raises go
// and counts cycles until main_done or the programmable cycle limit. The cycle
// count and the outcome (finished / timed_out) are held as status until the
// next start. abort returns to IDLE at any time and keeps the count.
module calyx_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 5,
    parameter int unsigned CNT_W        = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cycle_limit,
    input  logic             main_done,
    output logic             main_go,
    output logic             main_reset,
    output logic             busy,
    output logic             finished,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycles
);

    // The reset-phase counter is loaded with RESET_CYCLES-1 and leaves RESET at zero.
    localparam int unsigned     RC_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] limit;
    logic [RC_W-1:0]  rst_cnt;
    logic [CNT_W-1:0] cycles_next;
    logic             limit_hit;

    // Saturating increment of the run counter and full-width limit compare.
    always_comb begin
        cycles_next = (cycles == '1) ? cycles : cycles + CNT_W'(1);
        limit_hit   = (limit != '0) && ((cycles + CNT_W'(1)) == limit);
    end

    // Controller FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            main_go    <= 1'b0;
            main_reset <= 1'b1;
            busy       <= 1'b0;
            finished   <= 1'b0;
            timed_out  <= 1'b0;
            cycles     <= '0;
            limit      <= '0;
            rst_cnt    <= '0;
        end else if (abort) begin
            state      <= S_IDLE;
            main_go    <= 1'b0;
            main_reset <= 1'b1;
            busy       <= 1'b0;
            finished   <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RESET;
                        limit      <= cycle_limit;
                        cycles     <= '0;
                        finished   <= 1'b0;
                        timed_out  <= 1'b0;
                        rst_cnt    <= RC_LOAD;
                        main_reset <= 1'b1;
                        main_go    <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == '0) begin
                        state      <= S_RUN;
                        main_go    <= 1'b1;
                        main_reset <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt - RC_W'(1);
                    end
                end
                S_RUN: begin
                    cycles <= cycles_next;
                    if (main_done) begin
                        state    <= S_DONE;
                        finished <= 1'b1;
                        main_go  <= 1'b0;
                        busy     <= 1'b0;
                    end else if (limit_hit) begin
                        state     <= S_DONE;
                        timed_out <= 1'b1;
                        main_go   <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calyx_run_ctrl.sv
// tb_calyx_run_ctrl: directed scenarios plus randomized runs checked against a
// run-outcome model computed from the controller's rules.
module tb_calyx_run_ctrl;

    localparam int unsigned RC = 5;
    localparam int unsigned W  = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         main_done = 1'b0;
    logic [W-1:0] cycle_limit = '0;
    logic         main_go;
    logic         main_reset;
    logic         busy;
    logic         finished;
    logic         timed_out;
    logic [W-1:0] cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calyx_run_ctrl #(.RESET_CYCLES(RC), .CNT_W(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .cycle_limit(cycle_limit),
        .main_done(main_done),
        .main_go(main_go),
        .main_reset(main_reset),
        .busy(busy),
        .finished(finished),
        .timed_out(timed_out),
        .cycles(cycles)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outcome of one run: the run ends at the first done edge if it is within the
    // limit (done wins a tie), otherwise at the limit edge; an abort at or before
    // that edge ends it early and keeps the count of completed RUN edges.
    function automatic void model(input logic [W-1:0] limit, input int done_at, input int abort_at,
                                  output int exp_go, output logic [W-1:0] exp_cycles,
                                  output logic exp_fin, output logic exp_to, output logic exp_mreset);
        int   end_edge;
        logic by_done;
        if (done_at != 0 && (limit == 0 || done_at <= limit)) begin
            end_edge = done_at;
            by_done  = 1'b1;
        end else begin
            end_edge = int'(limit);
            by_done  = 1'b0;
        end
        if (abort_at != 0 && abort_at <= end_edge) begin
            exp_go     = abort_at;
            exp_cycles = W'(abort_at - 1);
            exp_fin    = 1'b0;
            exp_to     = 1'b0;
            exp_mreset = 1'b1;
        end else begin
            exp_go     = end_edge;
            exp_cycles = W'(end_edge);
            exp_fin    = by_done;
            exp_to     = ~by_done;
            exp_mreset = 1'b0;
        end
    endfunction

    // Drives one run from IDLE/DONE; pulses done/abort/extra start on the given
    // RUN edge (1-based, 0 = never) and measures reset-phase and go lengths.
    task automatic run_once(input logic [W-1:0] limit, input int done_at, input int abort_at,
                            input int extra_start_at, output int rst_seen, output int go_seen,
                            output logic timeout);
        start       = 1'b1;
        cycle_limit = limit;
        step();
        start       = 1'b0;
        cycle_limit = {$urandom, $urandom};
        rst_seen = 0;
        while (main_reset && busy && !main_go && rst_seen < 100) begin
            rst_seen++;
            step();
        end
        go_seen = 0;
        while (main_go && go_seen < 1000) begin
            go_seen++;
            main_done = (go_seen == done_at);
            abort     = (go_seen == abort_at);
            start     = (go_seen == extra_start_at);
            step();
            main_done = 1'b0;
            abort     = 1'b0;
            start     = 1'b0;
        end
        timeout = (rst_seen >= 100) || (go_seen >= 1000);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++; if (main_reset !== 1'b1) begin errors++; $display("FAIL reset_main_reset got %b want 1", main_reset); end
        checks++; if (main_go !== 1'b0) begin errors++; $display("FAIL reset_main_go got %b want 0", main_go); end
        checks++; if ({busy, finished, timed_out} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, finished, timed_out}); end
        checks++; if (cycles !== '0) begin errors++; $display("FAIL reset_cycles got %0d want 0", cycles); end
        step();
        step();
        reset = 1'b0;
        step();
        checks++; if ({main_reset, main_go, busy} !== 3'b100) begin errors++; $display("FAIL idle_outputs got %b want 100", {main_reset, main_go, busy}); end
    endtask

    task automatic test_done();
        int r, g;
        logic to;
        run_once('0, 10, 0, 0, r, g, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL done_timeout got %b want 0", to); end
        checks++; if (r !== RC) begin errors++; $display("FAIL done_reset_len got %0d want %0d", r, RC); end
        checks++; if (g !== 10) begin errors++; $display("FAIL done_go_len got %0d want 10", g); end
        checks++; if (cycles !== 64'd10) begin errors++; $display("FAIL done_cycles got %0d want 10", cycles); end
        checks++; if ({finished, timed_out, busy} !== 3'b100) begin errors++; $display("FAIL done_flags got %b want 100", {finished, timed_out, busy}); end
        checks++; if (main_reset !== 1'b0) begin errors++; $display("FAIL done_main_reset got %b want 0", main_reset); end
        step();
        step();
        checks++; if ({finished, cycles} !== {1'b1, 64'd10}) begin errors++; $display("FAIL done_hold got %b/%0d want 1/10", finished, cycles); end
    endtask

    task automatic test_limit();
        int r, g;
        logic to;
        run_once(64'd7, 0, 0, 0, r, g, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL limit_timeout got %b want 0", to); end
        checks++; if (g !== 7) begin errors++; $display("FAIL limit_go_len got %0d want 7", g); end
        checks++; if (cycles !== 64'd7) begin errors++; $display("FAIL limit_cycles got %0d want 7", cycles); end
        checks++; if ({finished, timed_out, busy, main_go} !== 4'b0100) begin errors++; $display("FAIL limit_flags got %b want 0100", {finished, timed_out, busy, main_go}); end
    endtask

    task automatic test_done_at_limit();
        int r, g;
        logic to;
        run_once(64'd4, 4, 0, 0, r, g, to);
        checks++; if (g !== 4) begin errors++; $display("FAIL tie_go_len got %0d want 4", g); end
        checks++; if (cycles !== 64'd4) begin errors++; $display("FAIL tie_cycles got %0d want 4", cycles); end
        checks++; if ({finished, timed_out} !== 2'b10) begin errors++; $display("FAIL tie_flags got %b want 10", {finished, timed_out}); end
    endtask

    task automatic test_limit_one();
        int r, g;
        logic to;
        run_once(64'd1, 0, 0, 0, r, g, to);
        checks++; if (g !== 1) begin errors++; $display("FAIL lim1_go_len got %0d want 1", g); end
        checks++; if ({cycles, timed_out, finished} !== {64'd1, 2'b10}) begin errors++; $display("FAIL lim1_status got %0d/%b/%b want 1/1/0", cycles, timed_out, finished); end
    endtask

    task automatic test_start_while_busy();
        int r, g, n;
        logic to;
        run_once('0, 6, 0, 3, r, g, to);
        checks++; if (g !== 6) begin errors++; $display("FAIL busy_start_go_len got %0d want 6", g); end
        checks++; if ({cycles, finished} !== {64'd6, 1'b1}) begin errors++; $display("FAIL busy_start_status got %0d/%b want 6/1", cycles, finished); end
        // restart from DONE
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if ({finished, timed_out, cycles} !== {2'b00, 64'd0}) begin errors++; $display("FAIL restart_clear got %b%b/%0d want 00/0", finished, timed_out, cycles); end
        checks++; if ({main_reset, busy, main_go} !== 3'b110) begin errors++; $display("FAIL restart_state got %b want 110", {main_reset, busy, main_go}); end
        n = 0;
        while (main_reset && busy && !main_go && n < 100) begin
            n++;
            step();
        end
        checks++; if (n !== RC) begin errors++; $display("FAIL restart_reset_len got %0d want %0d", n, RC); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if ({main_reset, busy, main_go, cycles} !== {3'b100, 64'd0}) begin errors++; $display("FAIL restart_abort got %b/%0d want 100/0", {main_reset, busy, main_go}, cycles); end
    endtask

    task automatic test_abort();
        int r, g;
        logic to;
        // abort and done together on the edge after 5 completed RUN edges
        run_once('0, 6, 6, 0, r, g, to);
        checks++; if (g !== 6) begin errors++; $display("FAIL abort_go_len got %0d want 6", g); end
        checks++; if (cycles !== 64'd5) begin errors++; $display("FAIL abort_cycles got %0d want 5", cycles); end
        checks++; if ({finished, timed_out, busy, main_reset} !== 4'b0001) begin errors++; $display("FAIL abort_flags got %b want 0001", {finished, timed_out, busy, main_reset}); end
    endtask

    task automatic test_random();
        logic [W-1:0] lim, exp_cycles;
        int           done_at, abort_at, xs, r, g, exp_go;
        logic         to, exp_fin, exp_to, exp_mreset;
        for (int i = 0; i < 30; i++) begin
            lim      = W'($urandom_range(0, 12));
            done_at  = $urandom_range(0, 14);
            if (lim == 0 && done_at == 0) done_at = $urandom_range(1, 14);
            abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            xs       = $urandom_range(0, 6);
            model(lim, done_at, abort_at, exp_go, exp_cycles, exp_fin, exp_to, exp_mreset);
            run_once(lim, done_at, abort_at, xs, r, g, to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout got %b want 0", i, to); end
            checks++; if (r !== RC) begin errors++; $display("FAIL rnd%0d_reset_len got %0d want %0d", i, r, RC); end
            checks++; if (g !== exp_go) begin errors++; $display("FAIL rnd%0d_go_len got %0d want %0d", i, g, exp_go); end
            checks++; if (cycles !== exp_cycles) begin errors++; $display("FAIL rnd%0d_cycles got %0d want %0d", i, cycles, exp_cycles); end
            checks++; if ({finished, timed_out} !== {exp_fin, exp_to}) begin errors++; $display("FAIL rnd%0d_flags got %b%b want %b%b", i, finished, timed_out, exp_fin, exp_to); end
            checks++; if ({main_reset, busy, main_go} !== {exp_mreset, 2'b00}) begin errors++; $display("FAIL rnd%0d_outputs got %b want %b00", i, {main_reset, busy, main_go}, exp_mreset); end
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    task automatic test_async_reset();
        int n;
        start       = 1'b1;
        cycle_limit = '0;
        step();
        start = 1'b0;
        n = 0;
        while (!main_go && n < 100) begin
            n++;
            step();
        end
        step();
        step();
        step();
        checks++; if ({main_go, cycles} !== {1'b1, 64'd3}) begin errors++; $display("FAIL async_pre got %b/%0d want 1/3", main_go, cycles); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({main_go, main_reset, busy} !== 3'b010) begin errors++; $display("FAIL async_outputs got %b want 010", {main_go, main_reset, busy}); end
        checks++; if (cycles !== '0) begin errors++; $display("FAIL async_cycles got %0d want 0", cycles); end
        #2 reset = 1'b0;
        step();
        checks++; if ({main_go, main_reset, busy, cycles} !== {3'b010, 64'd0}) begin errors++; $display("FAIL async_after got %b/%0d want 010/0", {main_go, main_reset, busy}, cycles); end
    endtask

    initial begin
        test_reset();
        test_done();
        test_limit();
        test_done_at_limit();
        test_limit_one();
        test_start_while_busy();
        test_abort();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
